// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad scanner: FSM states,
// the row/column key map and helpers that decode a sampled row pattern.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } row_hit_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Nibble at {row, col} is the hex digit printed on that key.
  localparam logic [63:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [5:0] base;
    base = {r, c, 2'b00};
    return KEY_MAP[base +: 4];
  endfunction

  // Only patterns with exactly one low row identify a single key.
  function automatic row_hit_t single_low(input logic [3:0] rows);
    row_hit_t res;
    case (rows)
      4'b1110: res = '{hit: 1'b1, idx: 2'd0};
      4'b1101: res = '{hit: 1'b1, idx: 2'd1};
      4'b1011: res = '{hit: 1'b1, idx: 2'd2};
      4'b0111: res = '{hit: 1'b1, idx: 2'd3};
      default: res = '{hit: 1'b0, idx: 2'd0};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static asynchronous inputs.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Resolve metastability over two stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounced press/release detection that shifts
// each accepted digit into a 16-bit entry register.
module hex_keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clr,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int             TW        = $clog2(SCAN_TICKS);
  localparam logic [TW-1:0]  TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [3:0]     DB_LAST   = 4'(DEBOUNCE_SCANS);

  logic [3:0]    row_s;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    ci_q, ci_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [1:0]    ridx_q, ridx_d;
  logic [3:0]    col_q, col_d;
  logic [15:0]   value_q, value_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;

  logic          sample;
  logic          accept;
  logic [1:0]    acc_row;
  logic [3:0]    acc_code;
  row_hit_t      hit;

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_row_sync (
    .clk (clk_100MHz),
    .rst (rst),
    .d   (row),
    .q   (row_s)
  );

  // Next-state logic for timer, scan FSM and the entry register
  always_comb begin
    state_d     = state_q;
    ci_d        = ci_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    ridx_d      = ridx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    accept      = 1'b0;
    acc_row     = ridx_q;
    hit         = single_low(row_s);
    sample      = (timer_q == TICK_LAST);
    timer_d     = sample ? {TW{1'b0}} : timer_q + TW'(1);

    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (hit.hit) begin
            pat_d  = row_s;
            ridx_d = hit.idx;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              acc_row = hit.idx;
              state_d = ST_HELD;
            end else begin
              cnt_d   = 4'd1;
              state_d = ST_DEBOUNCE;
            end
          end else begin
            ci_d = ci_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_s == pat_q) begin
            if (cnt_q + 4'd1 == DB_LAST) begin
              accept  = 1'b1;
              state_d = ST_HELD;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = ST_SCAN;
            ci_d    = ci_q + 2'd1;
          end
        end
        ST_HELD: begin
          // Column stays frozen while held, so other keys cannot be seen
          if (row_s == 4'hF) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d = ST_SCAN;
              ci_d    = ci_q + 2'd1;
            end else begin
              cnt_d   = 4'd1;
              state_d = ST_RELEASE;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        ST_RELEASE: begin
          if (row_s == 4'hF) begin
            if (cnt_q + 4'd1 == DB_LAST) begin
              state_d = ST_SCAN;
              ci_d    = ci_q + 2'd1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    acc_code = key_lookup(acc_row, ci_q);
    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = acc_code;
    end else begin
      key_code_d = key_code_q;
    end

    // Clear has priority over shifting in a new digit
    if (clr) begin
      value_d = 16'h0000;
    end else if (accept) begin
      value_d = {value_q[11:0], acc_code};
    end else begin
      value_d = value_q;
    end

    col_d = ~(4'b0001 << ci_d);
  end

  // State and registered outputs
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      timer_q     <= {TW{1'b0}};
      ci_q        <= 2'd0;
      cnt_q       <= 4'd0;
      pat_q       <= 4'hF;
      ridx_q      <= 2'd0;
      col_q       <= COL_RESET;
      value_q     <= 16'h0000;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ci_q        <= ci_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      ridx_q      <= ridx_d;
      col_q       <= col_d;
      value_q     <= value_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col       = col_q;
  assign value     = value_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a behavioural 4x4 keypad model.
module tb_hex_keypad_entry;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        clr;
  logic [15:0] value;
  logic [3:0]  key_code;
  logic        key_valid;

  logic [3:0][3:0] pressed;
  logic            glitch;

  int checks;
  int errors;
  int pulses;
  int col_bad;
  int base;
  logic ok;

  typedef struct {
    int         r;
    int         c;
    bit         clr_first;
    logic [3:0] code;
    logic [15:0] val;
  } vec_t;

  vec_t vecs [6];

  hex_keypad_entry #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
    .clk_100MHz (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .clr        (clr),
    .value      (value),
    .key_code   (key_code),
    .key_valid  (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a row reads low when a pressed key in that row sits on the driven column
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r][c] && !col[c]) row[r] = 1'b0;
      end
    end
    if (glitch) row = 4'hF;
  end

  always @(posedge clk) begin
    if (key_valid) pulses++;
  end

  always @(negedge clk) begin
    if (!rst && !(col inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) col_bad++;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output logic got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (key_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_col(input logic [3:0] target, output logic got);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (col == target) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [3:0] col_of(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    pulses  = 0;
    col_bad = 0;
    pressed = '0;
    glitch  = 1'b0;
    clr     = 1'b0;
    rst     = 1'b1;

    vecs[0] = '{1, 2, 1'b0, 4'h6, 16'h0006};
    vecs[1] = '{0, 0, 1'b1, 4'h1, 16'h0001};
    vecs[2] = '{0, 3, 1'b0, 4'hA, 16'h001A};
    vecs[3] = '{3, 0, 1'b0, 4'h0, 16'h01A0};
    vecs[4] = '{3, 1, 1'b0, 4'hF, 16'h1A0F};
    vecs[5] = '{3, 3, 1'b0, 4'hD, 16'hA0FD};

    repeat (3) @(posedge clk);
    #1;
    check("rst_col", {12'h0, col}, 16'h000E);
    check("rst_value", value, 16'h0000);
    check("rst_code", {12'h0, key_code}, 16'h0000);
    check("rst_valid", {15'h0, key_valid}, 16'h0000);
    rst = 1'b0;

    // Table: one key per record, released before the next
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].clr_first) begin
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_value", value, 16'h0000);
      end
      base = pulses;
      wait_col(col_of((vecs[v].c + 3) % 4), ok);
      if (!ok) check("col_timeout", 16'h0, 16'h1);
      pressed[vecs[v].r][vecs[v].c] = 1'b1;
      wait_valid(ok);
      check("accept_seen", {15'h0, ok}, 16'h0001);
      check("key_code", {12'h0, key_code}, {12'h0, vecs[v].code});
      check("value", value, vecs[v].val);
      check("col_frozen", {12'h0, col}, {12'h0, col_of(vecs[v].c)});
      @(posedge clk); #1;
      check("valid_width", {15'h0, key_valid}, 16'h0000);
      pressed = '0;
      repeat (30) @(posedge clk);
      #1;
      check("one_pulse", 16'(pulses - base), 16'h0001);
    end

    // Bounce: rows read high at the second sample of the debounce window
    base = pulses;
    wait_col(col_of(0), ok);
    pressed[2][1] = 1'b1;
    wait_col(col_of(1), ok);
    if (!ok) check("col_timeout", 16'h0, 16'h1);
    repeat (4) @(posedge clk);
    #1 glitch = 1'b1;
    repeat (3) @(posedge clk);
    #1 glitch = 1'b0;
    pressed = '0;
    @(posedge clk); #1;
    check("bounce_next_col", {12'h0, col}, {12'h0, col_of(2)});
    repeat (40) @(posedge clk);
    #1;
    check("bounce_no_pulse", 16'(pulses - base), 16'h0000);

    // Two rows low in the same column
    base = pulses;
    pressed[0][2] = 1'b1;
    pressed[1][2] = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("two_rows_no_pulse", 16'(pulses - base), 16'h0000);
    pressed = '0;
    repeat (20) @(posedge clk);

    // Second key while the first is held
    base = pulses;
    pressed[2][2] = 1'b1;
    wait_valid(ok);
    check("held_first_seen", {15'h0, ok}, 16'h0001);
    check("held_first_code", {12'h0, key_code}, 16'h0009);
    check("held_first_value", value, 16'h0FD9);
    pressed[0][0] = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("held_second_ignored", 16'(pulses - base), 16'h0001);
    pressed = '0;
    repeat (30) @(posedge clk);
    #1;
    check("held_after_release", 16'(pulses - base), 16'h0001);

    // Clear coinciding with accept of key 5
    clr = 1'b1;
    pressed[1][1] = 1'b1;
    wait_valid(ok);
    check("clr_accept_seen", {15'h0, ok}, 16'h0001);
    check("clr_accept_value", value, 16'h0000);
    check("clr_accept_code", {12'h0, key_code}, 16'h0005);
    clr = 1'b0;
    pressed = '0;
    repeat (30) @(posedge clk);

    // Reset in the middle of DEBOUNCE
    wait_col(col_of(3), ok);
    pressed[0][0] = 1'b1;
    wait_col(col_of(0), ok);
    if (!ok) check("col_timeout", 16'h0, 16'h1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_col", {12'h0, col}, 16'h000E);
    check("midrst_value", value, 16'h0000);
    check("midrst_code", {12'h0, key_code}, 16'h0000);
    check("midrst_valid", {15'h0, key_valid}, 16'h0000);
    pressed = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    base = pulses;
    repeat (60) @(posedge clk);
    #1;
    check("midrst_no_pulse", 16'(pulses - base), 16'h0000);
    check("col_one_hot_low", 16'(col_bad), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
